// File: rtl/mips_dbg_pkg.sv
// Shared encodings for the MIPS run/debug controller: run states, command opcodes and stop causes.
package mips_dbg_pkg;

  localparam logic [1:0] ST_HOLD = 2'b00;
  localparam logic [1:0] ST_STOP = 2'b01;
  localparam logic [1:0] ST_RUN  = 2'b10;
  localparam logic [1:0] ST_STEP = 2'b11;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_RUN  = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  localparam logic [2:0] CAUSE_NONE    = 3'd0;
  localparam logic [2:0] CAUSE_RESET   = 3'd1;
  localparam logic [2:0] CAUSE_USER    = 3'd2;
  localparam logic [2:0] CAUSE_STEP    = 3'd3;
  localparam logic [2:0] CAUSE_BREAK   = 3'd4;
  localparam logic [2:0] CAUSE_HALT    = 3'd5;
  localparam logic [2:0] CAUSE_TIMEOUT = 3'd6;

  function automatic logic core_active(input logic [1:0] st);
    return (st == ST_RUN) || (st == ST_STEP);
  endfunction

endpackage

// File: rtl/mips_bp_match.sv
// Breakpoint address/enable registers with a write port and a per-channel PC match vector.
// Match reads the registered values, so a write only affects matching from the next cycle.
module mips_bp_match #(
  parameter int PC_W     = 32,
  parameter int NUM_BP   = 2,
  parameter int BP_IDX_W = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                wr_en_i,
  input  logic [BP_IDX_W-1:0] idx_i,
  input  logic [PC_W-1:0]     addr_i,
  input  logic                enable_i,
  input  logic [PC_W-1:0]     pc_i,
  output logic [NUM_BP-1:0]   match_o
);

  logic [PC_W-1:0]   addr_q [NUM_BP];
  logic [NUM_BP-1:0] en_q;

  // Full-width index compare: out-of-range indices select no channel.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_BP; i++) begin
        addr_q[i] <= '0;
        en_q[i]   <= 1'b0;
      end
    end else if (wr_en_i) begin
      for (int i = 0; i < NUM_BP; i++) begin
        if (idx_i == BP_IDX_W'(i)) begin
          addr_q[i] <= addr_i;
          en_q[i]   <= enable_i;
        end
      end
    end
  end

  always_comb begin
    match_o = '0;
    for (int i = 0; i < NUM_BP; i++) begin
      match_o[i] = en_q[i] && (addr_q[i] == pc_i);
    end
  end

endmodule

// File: rtl/mips_run_ctrl.sv
// Run/debug controller: sequences core reset, gates the core clock-enable and stops the core
// on halt request, breakpoint, cycle timeout, single-step completion or user command.
module mips_run_ctrl
  import mips_dbg_pkg::*;
#(
  parameter int PC_W       = 32,
  parameter int CNT_W      = 32,
  parameter int NUM_BP     = 2,
  parameter int BP_IDX_W   = 1,
  parameter int RST_HOLD   = 4,
  parameter int MAX_CYCLES = 0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cmd_valid,
  input  logic [1:0]          cmd_op,
  output logic                cmd_ready,
  input  logic                bp_wr_en,
  input  logic [BP_IDX_W-1:0] bp_idx,
  input  logic [PC_W-1:0]     bp_addr,
  input  logic                bp_enable,
  input  logic [PC_W-1:0]     core_pc,
  input  logic                core_instr_done,
  input  logic                core_halt_req,
  output logic                core_rst,
  output logic                core_en,
  output logic [1:0]          state,
  output logic [2:0]          stop_cause,
  output logic [NUM_BP-1:0]   bp_hit,
  output logic [CNT_W-1:0]    cycle_cnt,
  output logic [CNT_W-1:0]    instr_cnt
);

  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  logic [1:0]        state_q, state_d;
  logic [2:0]        cause_q, cause_d;
  logic [NUM_BP-1:0] hit_q, hit_d;
  logic [CNT_W-1:0]  cyc_q, cyc_d;
  logic [CNT_W-1:0]  ins_q, ins_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              core_en_q, core_rst_q;
  logic [NUM_BP-1:0] bp_match;
  logic              cmd_fire, user_halt, timeout;

  mips_bp_match #(
    .PC_W     (PC_W),
    .NUM_BP   (NUM_BP),
    .BP_IDX_W (BP_IDX_W)
  ) u_bp (
    .clock    (clock),
    .reset    (reset),
    .wr_en_i  (bp_wr_en && (state_q != ST_HOLD)),
    .idx_i    (bp_idx),
    .addr_i   (bp_addr),
    .enable_i (bp_enable),
    .pc_i     (core_pc),
    .match_o  (bp_match)
  );

  assign cmd_ready = (state_q != ST_HOLD);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign user_halt = cmd_fire && (cmd_op == OP_HALT);
  // Counter is pre-increment here, so this fires on the MAX_CYCLES-th enabled cycle.
  assign timeout   = (MAX_CYCLES != 0) && ((cyc_q + CNT_W'(1)) == CNT_W'(MAX_CYCLES));

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    hit_d   = hit_q;
    hold_d  = hold_q;
    cyc_d   = cyc_q;
    ins_d   = ins_q;
    if (core_en_q && (cyc_q != '1)) cyc_d = cyc_q + CNT_W'(1);
    if (core_en_q && core_instr_done && (ins_q != '1)) ins_d = ins_q + CNT_W'(1);
    case (state_q)
      ST_HOLD: begin
        hold_d = hold_q + HOLD_W'(1);
        if (hold_q == HOLD_W'(RST_HOLD - 1)) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (cmd_fire) begin
          case (cmd_op)
            OP_RUN:  begin state_d = ST_RUN;  cause_d = CAUSE_NONE; hit_d = '0; end
            OP_STEP: begin state_d = ST_STEP; cause_d = CAUSE_NONE; hit_d = '0; end
            OP_NOP, OP_HALT: ;
          endcase
        end
      end
      ST_RUN: begin
        if (core_halt_req) begin
          state_d = ST_STOP; cause_d = CAUSE_HALT;
        end else if (core_instr_done && (|bp_match)) begin
          state_d = ST_STOP; cause_d = CAUSE_BREAK; hit_d = bp_match;
        end else if (timeout) begin
          state_d = ST_STOP; cause_d = CAUSE_TIMEOUT;
        end else if (user_halt) begin
          state_d = ST_STOP; cause_d = CAUSE_USER;
        end
      end
      default: begin
        if (core_halt_req) begin
          state_d = ST_STOP; cause_d = CAUSE_HALT;
        end else if (core_instr_done) begin
          state_d = ST_STOP; cause_d = CAUSE_STEP;
        end else if (user_halt) begin
          state_d = ST_STOP; cause_d = CAUSE_USER;
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_HOLD;
      cause_q    <= CAUSE_RESET;
      hit_q      <= '0;
      cyc_q      <= '0;
      ins_q      <= '0;
      hold_q     <= '0;
      core_en_q  <= 1'b0;
      core_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      hit_q      <= hit_d;
      cyc_q      <= cyc_d;
      ins_q      <= ins_d;
      hold_q     <= hold_d;
      core_en_q  <= core_active(state_d);
      core_rst_q <= (state_d == ST_HOLD);
    end
  end

  assign core_rst   = core_rst_q;
  assign core_en    = core_en_q;
  assign state      = state_q;
  assign stop_cause = cause_q;
  assign bp_hit     = hit_q;
  assign cycle_cnt  = cyc_q;
  assign instr_cnt  = ins_q;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Bench for mips_run_ctrl: directed scenarios with literal expectations plus a randomized run,
// all checked every cycle against a behavioural model of the run/stop rules.
module tb_mips_run_ctrl;

  localparam int PC_W = 32, CNT_W = 32, NUM_BP = 2, BP_IDX_W = 2;
  localparam int RST_HOLD = 4, MAX_CYCLES = 20;
  localparam logic [31:0] PC_BASE = 32'h0040_0000;
  localparam longint CNT_MAX = 64'hFFFF_FFFF;

  logic clock = 1'b0;
  logic reset;
  logic cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic bp_wr_en, bp_enable;
  logic [BP_IDX_W-1:0] bp_idx;
  logic [PC_W-1:0] bp_addr, core_pc;
  logic core_instr_done, core_halt_req, core_rst, core_en;
  logic [1:0] state;
  logic [2:0] stop_cause;
  logic [NUM_BP-1:0] bp_hit;
  logic [CNT_W-1:0] cycle_cnt, instr_cnt;

  mips_run_ctrl #(
    .PC_W(PC_W), .CNT_W(CNT_W), .NUM_BP(NUM_BP), .BP_IDX_W(BP_IDX_W),
    .RST_HOLD(RST_HOLD), .MAX_CYCLES(MAX_CYCLES)
  ) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
    .bp_wr_en(bp_wr_en), .bp_idx(bp_idx), .bp_addr(bp_addr), .bp_enable(bp_enable),
    .core_pc(core_pc), .core_instr_done(core_instr_done), .core_halt_req(core_halt_req),
    .core_rst(core_rst), .core_en(core_en), .state(state), .stop_cause(stop_cause),
    .bp_hit(bp_hit), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  always #5 clock = ~clock;

  int ntests = 0, nfail = 0;

  // Model: mode 0 HOLD, 1 STOP, 2 RUN, 3 STEP
  int m_mode, m_hold, m_cause;
  logic [NUM_BP-1:0] m_hit;
  longint m_cyc, m_ins;
  logic [31:0] m_bpa [NUM_BP];
  bit m_bpe [NUM_BP];
  // Simple core: one instruction per 4 enabled cycles (or random in the random phase)
  logic [31:0] c_pc;
  int c_ph;
  bit rand_core = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_hold = RST_HOLD; m_cause = 1; m_hit = '0; m_cyc = 0; m_ins = 0;
    for (int i = 0; i < NUM_BP; i++) begin m_bpa[i] = '0; m_bpe[i] = 0; end
    c_pc = PC_BASE; c_ph = 0;
  endtask

  task automatic model_step();
    bit en, done, halt, acc, tmo;
    logic [NUM_BP-1:0] hits;
    en   = (m_mode >= 2);
    done = en && core_instr_done;
    halt = en && core_halt_req;
    acc  = cmd_valid && (m_mode != 0);
    hits = '0;
    for (int i = 0; i < NUM_BP; i++) hits[i] = m_bpe[i] && (m_bpa[i] == core_pc);
    tmo = (MAX_CYCLES != 0) && (m_cyc + 1 == MAX_CYCLES);
    if (reset) begin
      model_reset();
    end else begin
      case (m_mode)
        0: begin m_hold--; if (m_hold == 0) m_mode = 1; end
        1: if (acc && (cmd_op == 2'b01 || cmd_op == 2'b10)) begin
             m_mode = (cmd_op == 2'b01) ? 2 : 3; m_cause = 0; m_hit = '0;
           end
        2: if (halt) begin m_mode = 1; m_cause = 5; end
           else if (done && hits != 0) begin m_mode = 1; m_cause = 4; m_hit = hits; end
           else if (tmo) begin m_mode = 1; m_cause = 6; end
           else if (acc && cmd_op == 2'b11) begin m_mode = 1; m_cause = 2; end
        default: if (halt) begin m_mode = 1; m_cause = 5; end
           else if (done) begin m_mode = 1; m_cause = 3; end
           else if (acc && cmd_op == 2'b11) begin m_mode = 1; m_cause = 2; end
      endcase
      if (en && m_cyc < CNT_MAX) m_cyc++;
      if (done && m_ins < CNT_MAX) m_ins++;
      if (bp_wr_en && acc_state_ok() && int'(bp_idx) < NUM_BP) begin
        m_bpa[bp_idx] = bp_addr; m_bpe[bp_idx] = bp_enable;
      end
    end
  endtask

  // Breakpoint writes use the pre-step mode; called before m_mode changes would matter,
  // so track the pre-step mode separately.
  int m_mode_prev;
  function automatic bit acc_state_ok();
    return m_mode_prev != 0;
  endfunction

  task automatic compare_all();
    chk("state", {62'd0, state}, m_mode);
    chk("core_rst", {63'd0, core_rst}, (m_mode == 0));
    chk("core_en", {63'd0, core_en}, (m_mode >= 2));
    chk("cmd_ready", {63'd0, cmd_ready}, (m_mode != 0));
    chk("stop_cause", {61'd0, stop_cause}, m_cause);
    chk("bp_hit", {62'd0, bp_hit}, {62'd0, m_hit});
    chk("cycle_cnt", {32'd0, cycle_cnt}, m_cyc);
    chk("instr_cnt", {32'd0, instr_cnt}, m_ins);
  endtask

  task automatic tick();
    bit en_old, done_drv;
    if (rand_core) core_instr_done = ($urandom_range(0, 2) == 0);
    else core_instr_done = (m_mode >= 2) && (c_ph == 3);
    core_pc = core_instr_done ? c_pc + 32'd4 : c_pc;
    done_drv = core_instr_done;
    en_old = (m_mode >= 2);
    m_mode_prev = m_mode;
    model_step();
    @(posedge clock); #1;
    if (en_old) begin
      if (done_drv) begin c_pc = c_pc + 32'd4; c_ph = 0; end
      else c_ph = (c_ph + 1) % 4;
    end
    if (m_mode == 0) begin c_pc = PC_BASE; c_ph = 0; end
    if (rand_core && c_pc > PC_BASE + 32'd60) c_pc = PC_BASE;
    cmd_valid = 0; bp_wr_en = 0;
    compare_all();
  endtask

  task automatic wait_stop(input int max, output int en_cycles);
    int k;
    en_cycles = 0; k = 0;
    while (state !== 2'b01 && k < max) begin
      if (core_en === 1'b1) en_cycles++;
      tick(); k++;
    end
    if (state !== 2'b01) chk("wait_stop_timeout", {62'd0, state}, 1);
  endtask

  task automatic do_reset();
    int n;
    reset = 1; #1;
    chk("rst_state", {62'd0, state}, 0);
    chk("rst_core_rst", {63'd0, core_rst}, 1);
    chk("rst_core_en", {63'd0, core_en}, 0);
    chk("rst_cmd_ready", {63'd0, cmd_ready}, 0);
    chk("rst_cause", {61'd0, stop_cause}, 1);
    chk("rst_cycle_cnt", {32'd0, cycle_cnt}, 0);
    chk("rst_instr_cnt", {32'd0, instr_cnt}, 0);
    model_reset();
    compare_all();
    @(posedge clock); #1;
    reset = 0;
    n = 0;
    while (core_rst === 1'b1 && n < 20) begin tick(); n++; end
    chk("hold_len", n, RST_HOLD);
  endtask

  task automatic send(input logic [1:0] op);
    cmd_valid = 1; cmd_op = op; tick();
  endtask

  task automatic bp_write(input int idx, input logic [31:0] a, input bit e);
    bp_wr_en = 1; bp_idx = BP_IDX_W'(idx); bp_addr = a; bp_enable = e; tick();
  endtask

  initial begin
    int n;
    reset = 0; cmd_valid = 0; cmd_op = 0; bp_wr_en = 0; bp_idx = 0; bp_addr = 0;
    bp_enable = 0; core_pc = PC_BASE; core_instr_done = 0; core_halt_req = 0;
    m_mode_prev = 0;
    #2;
    do_reset();
    chk("stop_state", {62'd0, state}, 1);
    chk("stop_cause_reset", {61'd0, stop_cause}, 1);
    chk("stop_cmd_ready", {63'd0, cmd_ready}, 1);
    chk("stop_core_en", {63'd0, core_en}, 0);

    // Single step
    send(2'b10);
    wait_stop(50, n);
    chk("step_en_cycles", n, 4);
    chk("step_cause", {61'd0, stop_cause}, 3);
    chk("step_instr_cnt", {32'd0, instr_cnt}, 1);
    chk("step_cycle_cnt", {32'd0, cycle_cnt}, 4);

    // Timeout with a simultaneous user HALT on the final cycle
    do_reset();
    send(2'b01);
    n = 0;
    while (state !== 2'b01 && n < 100) begin
      if (m_mode == 2 && m_cyc == 19) begin cmd_valid = 1; cmd_op = 2'b11; end
      tick(); n++;
    end
    chk("tmo_cause", {61'd0, stop_cause}, 6);
    chk("tmo_cycle_cnt", {32'd0, cycle_cnt}, 20);
    chk("tmo_instr_cnt", {32'd0, instr_cnt}, 5);

    // Two channels on the same PC; an out-of-range index write must be dropped
    do_reset();
    bp_write(0, 32'h0040_0010, 1);
    bp_write(1, 32'h0040_0010, 1);
    bp_write(2, 32'h0040_0004, 1);
    send(2'b01);
    wait_stop(100, n);
    chk("bp_cause", {61'd0, stop_cause}, 4);
    chk("bp_hit_both", {62'd0, bp_hit}, 2'b11);
    chk("bp_instr_cnt", {32'd0, instr_cnt}, 4);
    chk("bp_cycle_cnt", {32'd0, cycle_cnt}, 16);

    // Halt request coincident with a breakpoint match (and the timeout cycle)
    bp_write(0, 32'h0040_0014, 1);
    bp_write(1, 32'h0040_0014, 0);
    send(2'b01);
    n = 0;
    while (state !== 2'b01 && n < 100) begin
      core_halt_req = (m_mode >= 2) && (c_ph == 3);
      tick(); n++;
    end
    chk("halt_cause", {61'd0, stop_cause}, 5);
    chk("halt_bp_hit", {62'd0, bp_hit}, 0);
    core_halt_req = 1;
    send(2'b01);
    wait_stop(20, n);
    chk("rehalt_en_cycles", n, 1);
    chk("rehalt_cause", {61'd0, stop_cause}, 5);
    core_halt_req = 0;

    // Reset in the middle of a run clears everything, including breakpoints
    send(2'b01);
    for (int i = 0; i < 3; i++) tick();
    do_reset();
    send(2'b01);
    for (int i = 0; i < 17; i++) tick();
    chk("no_bp_after_reset", {62'd0, state}, 2);
    send(2'b11);
    chk("user_cause", {61'd0, stop_cause}, 2);
    chk("user_state", {62'd0, state}, 1);

    // Randomized traffic against the model
    rand_core = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) < 3) do_reset();
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_op = 2'($urandom_range(0, 3));
      bp_wr_en = ($urandom_range(0, 15) == 0);
      bp_idx = BP_IDX_W'($urandom_range(0, 3));
      bp_addr = PC_BASE + 32'(4 * $urandom_range(0, 15));
      bp_enable = 1'($urandom_range(0, 1));
      core_halt_req = ($urandom_range(0, 31) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", nfail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mips_run_ctrl.md
Name: mips_run_ctrl

Overview:
- Run/debug controller that sits between the bench (or host) and the multicycle MIPS core.
- Sequences core reset and gates the core through a clock-enable.
- Provides run, single-step and halt commands, cycle and instruction counters, NUM_BP PC breakpoints and a cycle-timeout stop.
- Generalises the free-running clock-only test fixture into a parametrised, controllable execution harness.

Parameters:
PC_W, 32, width of core PC and breakpoint addresses
CNT_W, 32, width of cycle/instruction counters
NUM_BP, 2, number of breakpoint channels (1..16)
BP_IDX_W, 1, width of bp_idx (>= clog2(NUM_BP), min 1)
RST_HOLD, 4, cycles core_rst is held after reset release (>=1)
MAX_CYCLES, 0, timeout in enabled cycles; 0 disables timeout

Ports:
clock  in  1  sole clock
reset  in  1  asynchronous, active-high
cmd_valid  in  1  command strobe
cmd_op  in  2  00 NOP, 01 RUN, 10 STEP, 11 HALT
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
bp_wr_en  in  1  breakpoint register write
bp_idx  in  BP_IDX_W  breakpoint channel select
bp_addr  in  PC_W  breakpoint PC
bp_enable  in  1  channel enable written with bp_addr
core_pc  in  PC_W  core PC (PC of next instruction when core_instr_done=1)
core_instr_done  in  1  one-cycle pulse at instruction completion
core_halt_req  in  1  level; core decoded break/syscall-exit
core_rst  out  1  reset to core
core_en  out  1  clock-enable to core
state  out  2  00 HOLD, 01 STOP, 10 RUN, 11 STEP
stop_cause  out  3  0 NONE, 1 RESET, 2 USER, 3 STEP, 4 BREAK, 5 HALT, 6 TIMEOUT
bp_hit  out  NUM_BP  channels that matched at last BREAK stop
cycle_cnt  out  CNT_W  enabled core cycles
instr_cnt  out  CNT_W  completed instructions

Behaviour:
- Reset (async): state=HOLD, core_rst=1, core_en=0, cmd_ready=0, stop_cause=RESET, bp_hit=0, counters=0, all bp enables=0.
- HOLD:
  - core_rst=1 for exactly RST_HOLD cycles after reset deasserts, then STOP.
  - core_rst=0 from the STOP cycle on.
  - Commands are not accepted.
- STOP:
  - core_en=0, cmd_ready=1.
  - RUN -> RUN next cycle, stop_cause=NONE, bp_hit cleared.
  - STEP -> STEP next cycle, stop_cause=NONE, bp_hit cleared.
  - HALT/NOP: stay in STOP.
- RUN: core_en=1, cmd_ready=1. Stop conditions are sampled each cycle; the first hit gives STOP next cycle with core_en=0 from that cycle. Priority:
  1. core_halt_req -> HALT.
  2. core_instr_done and any enabled bp with bp_addr==core_pc -> BREAK; bp_hit = all matching channels.
  3. Timeout: MAX_CYCLES!=0 and cycle_cnt+1==MAX_CYCLES on this enabled cycle -> TIMEOUT.
  4. Accepted HALT command -> USER.
  - RUN/STEP commands in RUN are accepted and ignored.
- STEP: core_en=1 until core_instr_done, then STOP with stop_cause=STEP.
  - core_halt_req still wins (HALT).
  - Accepted HALT command -> USER.
  - Breakpoints and timeout are ignored.
- Counters:
  - cycle_cnt += 1 on every cycle with core_en=1.
  - instr_cnt += 1 on core_instr_done with core_en=1.
  - Both saturate at all-ones; only reset clears them.
  - The count for the stopping cycle is included.
- Breakpoint writes:
  - Accepted in every state except HOLD; take effect next cycle.
  - A match in the same cycle as a write to that channel uses the old value.
  - bp_idx >= NUM_BP: write ignored.
- Resume after HALT while core_halt_req is still high: RUN lasts one enabled cycle, then HALT again (documented, not an error).
- core_instr_done or core_halt_req while core_en=0: ignored.
- Reset mid-RUN/STEP: immediate HOLD; all state lost.
- Outputs are registered, except cmd_ready, which is a function of state only.

Decomposition:
- Package mips_dbg_pkg: state encoding, cmd_op codes, stop_cause codes.
- Sub-module mips_bp_match: NUM_BP address/enable registers, write port, match vector output.
- FSM, counters and timeout live in mips_run_ctrl.

Test Plan:
- Reset release, RST_HOLD=4 -> core_rst high exactly 4 cycles, then state=STOP, stop_cause=1, cmd_ready=1, core_en=0.
- STEP with core model pulsing core_instr_done every 4 enabled cycles -> core_en high 4 cycles, stop_cause=3, instr_cnt=1, cycle_cnt=4.
- bp0=0x00400010 enabled, bp1 same address enabled, RUN, PCs step by 4 from 0x00400000 -> stop at the 4th instr_done, stop_cause=4, bp_hit=2'b11, instr_cnt=4.
- MAX_CYCLES=20, RUN without breakpoints -> stop after 20 enabled cycles, cycle_cnt=20, stop_cause=6; a simultaneous HALT command yields 6, not 2.
- core_halt_req and a matching breakpoint in the same cycle -> stop_cause=5, bp_hit=0; RUN with halt_req still high -> one enabled cycle, then stop_cause=5.
- Assert reset mid-RUN -> core_en=0 and core_rst=1 immediately, counters=0, breakpoints disabled; after release, HOLD sequence repeats.
